multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock, clk, with all state updated on its rising edge; reset rst SHALL be synchronous and active-high.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 opcode  in  6  instr[31:26] from the instruction register, valid from DECODE onward.
REQ-005 alu_zero  in  1  ALU zero flag, valid in BRANCH.
REQ-006 mem_ready  in  1  unified memory has completed the current access.
REQ-007 mem_req  out  1  memory access request.
REQ-008 mem_we  out  1  access is a write; valid only while mem_req=1.
REQ-009 mux_iord  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 ir_write  out  1  load instruction register.
REQ-011 pc_write  out  1  load PC, already qualified by the branch condition.
REQ-012 mux_pc_src  out  2  PC source: 00=ALU result, 01=ALUOut (branch target), 10=jump target.
REQ-013 write_reg  out  1  register-file write enable.
REQ-014 mux_write_rt_rd  out  1  destination register: 0=rt, 1=rd.
REQ-015 mux_alu_a  out  1  ALU A operand: 0=PC, 1=rs.
REQ-016 mux_alu_b  out  2  ALU B operand: 00=rt, 01=constant 4, 10=sign-extended imm, 11=imm<<2.
REQ-017 alu_op  out  4  ALU control code: 0000 add, 0001 sub/beq, 0010 R-type funct, 0011 and, 0100 bne.
REQ-018 mux_reg_src_alu_mem  out  1  write-back source: 1=ALUOut, 0=memory data.
REQ-019 illegal  out  1  unsupported opcode trapped; sticky until rst.

Function
REQ-020 SHALL be a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
REQ-021 FETCH SHALL drive mem_req=1, mem_we=0, mux_iord=0, mux_alu_a=0, mux_alu_b=01, alu_op=0000, mux_pc_src=00, and hold them until mem_ready=1.
REQ-022 In FETCH, ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1; the FSM SHALL then go to DECODE.
REQ-023 DECODE SHALL drive mux_alu_a=0, mux_alu_b=11, alu_op=0000 to precompute the branch target.
REQ-024 DECODE SHALL dispatch by opcode: 000000 -> EXEC_R; 001000, 001001, 001100 -> EXEC_I; 100011, 101011 -> ADDR; 000100, 000101 -> BRANCH; 000010 -> JUMP; any other opcode -> TRAP.
REQ-025 EXEC_R SHALL drive mux_alu_a=1, mux_alu_b=00, alu_op=0010, then go to WB_ALU with mux_write_rt_rd=1.
REQ-026 EXEC_I SHALL drive mux_alu_a=1, mux_alu_b=10, with alu_op=0011 for andi and 0000 otherwise, then go to WB_ALU with mux_write_rt_rd=0.
REQ-027 ADDR SHALL drive mux_alu_a=1, mux_alu_b=10, alu_op=0000, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-028 MEM_RD and MEM_WR SHALL drive mem_req=1 and mux_iord=1, with mem_we=1 in MEM_WR, held until mem_ready=1.
REQ-029 On mem_ready=1, MEM_RD SHALL go to WB_MEM and MEM_WR SHALL go to FETCH.
REQ-030 WB_ALU and WB_MEM SHALL pulse write_reg=1 for exactly one cycle, with mux_reg_src_alu_mem=1 and 0 respectively, then go to FETCH.
REQ-031 BRANCH SHALL drive mux_alu_a=1, mux_alu_b=00, mux_pc_src=01 and alu_op=0001 (beq) or 0100 (bne).
REQ-032 In BRANCH, pc_write SHALL equal (beq AND alu_zero) OR (bne AND NOT alu_zero); the FSM SHALL then go to FETCH.
REQ-033 JUMP SHALL drive mux_pc_src=10 and pc_write=1 for one cycle, then go to FETCH.
REQ-034 Latency with zero wait states SHALL be: R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3; each cycle mem_ready is low adds exactly one cycle.
REQ-035 mem_ready SHALL be ignored while mem_req=0; mem_req, mem_we and mux_iord SHALL remain stable while mem_req=1.
REQ-036 TRAP SHALL set illegal=1 and hold all enables (mem_req, pc_write, ir_write, write_reg) at 0 until rst.
REQ-037 In every state, outputs not listed for that state SHALL be 0.

Reset
REQ-038 rst=1 SHALL force state FETCH and illegal=0 on the next edge, overriding any pending memory wait or TRAP.
REQ-039 While rst=1, all enable outputs SHALL be 0; on the first cycle after rst drops, FETCH outputs SHALL appear.

Structure
REQ-040 Opcode constants, alu_op codes and state encoding SHALL live in a shared package, mips_ctrl_pkg.
REQ-041 One combinational sub-module, mc_opclass_decode (opcode -> instruction class plus immediate alu_op), SHALL be instantiated; it SHALL contain no state.

Verification
REQ-042 Reset: rst=1 for 2 cycles, then 0 -> mem_req=1, mux_iord=0, all enables 0, illegal=0.
REQ-043 Zero-wait add (opcode 000000, mem_ready=1 throughout) -> write_reg pulses in cycle 4 with mux_write_rt_rd=1; next fetch starts in cycle 5.
REQ-044 lw with mem_ready low for 3 cycles in MEM_RD -> mem_req held and stable throughout; write_reg with mux_reg_src_alu_mem=0 in cycle 8.
REQ-045 beq with alu_zero=1 -> pc_write=1, mux_pc_src=01 in cycle 3; bne with alu_zero=1 -> pc_write=0.
REQ-046 Opcode 111111 -> TRAP, illegal=1, no mem_req for 20 cycles; rst=1 then clears illegal and resumes FETCH.
REQ-047 rst asserted mid-MEM_WR with mem_ready=0 -> FETCH on the next edge, mem_we=0, no register write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: opcode constants,
// ALU control codes, FSM state encoding and the instruction classes produced
// by the opcode decoder.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Opcode field values (instr[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU control codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_BNE   = 4'b0100;

  // Mux select encodings
  localparam logic [1:0] ALUB_RT    = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_IMM, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundles the controller's datapath-facing signals.
//   master : the control unit (drives memory request and mux/enable lines)
//   slave  : the datapath/memory side (drives opcode, alu_zero, mem_ready)
// ---------------------------------------------------------------------------
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mux_iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] mux_pc_src;
  logic       write_reg;
  logic       mux_write_rt_rd;
  logic       mux_alu_a;
  logic [1:0] mux_alu_b;
  logic [3:0] alu_op;
  logic       mux_reg_src_alu_mem;
  logic       illegal;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output mem_req, mem_we, mux_iord, ir_write, pc_write, mux_pc_src,
           write_reg, mux_write_rt_rd, mux_alu_a, mux_alu_b, alu_op,
           mux_reg_src_alu_mem, illegal
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  mem_req, mem_we, mux_iord, ir_write, pc_write, mux_pc_src,
           write_reg, mux_write_rt_rd, mux_alu_a, mux_alu_b, alu_op,
           mux_reg_src_alu_mem, illegal
  );
endinterface

// File: rtl/mc_opclass_decode.sv
// ---------------------------------------------------------------------------
// mc_opclass_decode
// Purely combinational opcode classifier.
//   opcode     in  6  instruction opcode field
//   op_class   out    instruction class used for DECODE dispatch
//   imm_alu_op out 4  ALU code for immediate arithmetic (and for andi)
//   is_store   out 1  memory class instruction is sw (else lw)
//   is_bne     out 1  branch class instruction is bne (else beq)
// ---------------------------------------------------------------------------
module mc_opclass_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  output instr_class_t op_class,
  output logic [3:0]   imm_alu_op,
  output logic         is_store,
  output logic         is_bne
);

  // Map each supported opcode onto its class; anything unknown is illegal
  always_comb begin
    op_class   = CLS_ILLEGAL;
    imm_alu_op = ALU_ADD;
    is_store   = 1'b0;
    is_bne     = 1'b0;
    case (opcode)
      OP_RTYPE:          op_class = CLS_R;
      OP_ADDI, OP_ADDIU: op_class = CLS_IMM;
      OP_ANDI: begin
        op_class   = CLS_IMM;
        imm_alu_op = ALU_AND;
      end
      OP_LW:             op_class = CLS_MEM;
      OP_SW: begin
        op_class = CLS_MEM;
        is_store = 1'b1;
      end
      OP_BEQ:            op_class = CLS_BRANCH;
      OP_BNE: begin
        op_class = CLS_BRANCH;
        is_bne   = 1'b1;
      end
      OP_J:              op_class = CLS_JUMP;
      default:           op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore FSM controller for a multicycle MIPS subset (R-type, addi/addiu/andi,
// lw/sw, beq/bne, j) sharing one unified memory.
//   clk  in  system clock, all state on rising edge
//   rst  in  synchronous active-high reset
//   bus  master modport: opcode/alu_zero/mem_ready in; memory request,
//        mux selects, write enables, alu_op and sticky illegal flag out
// ---------------------------------------------------------------------------
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  state_t       state;
  state_t       next_state;
  instr_class_t op_class;
  logic [3:0]   imm_alu_op;
  logic         is_store;
  logic         is_bne;

  mc_opclass_decode u_decode (
    .opcode     (bus.opcode),
    .op_class   (op_class),
    .imm_alu_op (imm_alu_op),
    .is_store   (is_store),
    .is_bne     (is_bne)
  );

  // State register; reset wins over any pending memory wait or trap
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state and Moore outputs. The only input-qualified outputs are the
  // FETCH load strobes (on mem_ready) and the branch pc_write (on alu_zero).
  // Enables are forced low while rst is high so nothing fires during reset.
  always_comb begin
    next_state              = state;
    bus.mem_req             = 1'b0;
    bus.mem_we              = 1'b0;
    bus.mux_iord            = 1'b0;
    bus.ir_write            = 1'b0;
    bus.pc_write            = 1'b0;
    bus.mux_pc_src          = PCSRC_ALU;
    bus.write_reg           = 1'b0;
    bus.mux_write_rt_rd     = 1'b0;
    bus.mux_alu_a           = 1'b0;
    bus.mux_alu_b           = ALUB_RT;
    bus.alu_op              = ALU_ADD;
    bus.mux_reg_src_alu_mem = 1'b0;
    bus.illegal             = 1'b0;

    unique case (state)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.mux_alu_b = ALUB_FOUR;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next_state   = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.mux_alu_b = ALUB_IMMSH;
        case (op_class)
          CLS_R:      next_state = S_EXEC_R;
          CLS_IMM:    next_state = S_EXEC_I;
          CLS_MEM:    next_state = S_ADDR;
          CLS_BRANCH: next_state = S_BRANCH;
          CLS_JUMP:   next_state = S_JUMP;
          default:    next_state = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        bus.mux_alu_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        next_state    = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.mux_alu_a = 1'b1;
        bus.mux_alu_b = ALUB_IMM;
        bus.alu_op    = imm_alu_op;
        next_state    = S_WB_ALU;
      end
      S_ADDR: begin
        bus.mux_alu_a = 1'b1;
        bus.mux_alu_b = ALUB_IMM;
        next_state    = is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_req  = 1'b1;
        bus.mux_iord = 1'b1;
        if (bus.mem_ready) next_state = S_WB_MEM;
      end
      S_MEM_WR: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mux_iord = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_WB_ALU: begin
        // R-type writes rd, immediate forms write rt; opcode is still held in IR
        bus.write_reg           = 1'b1;
        bus.mux_reg_src_alu_mem = 1'b1;
        bus.mux_write_rt_rd     = (op_class == CLS_R);
        next_state              = S_FETCH;
      end
      S_WB_MEM: begin
        bus.write_reg = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        bus.mux_alu_a  = 1'b1;
        bus.mux_pc_src = PCSRC_OUT;
        bus.alu_op     = is_bne ? ALU_BNE : ALU_SUB;
        bus.pc_write   = is_bne ? ~bus.alu_zero : bus.alu_zero;
        next_state     = S_FETCH;
      end
      S_JUMP: begin
        bus.mux_pc_src = PCSRC_JMP;
        bus.pc_write   = 1'b1;
        next_state     = S_FETCH;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
        next_state  = S_TRAP;
      end
      default: next_state = S_FETCH;
    endcase

    if (rst) begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.write_reg = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed-vector bench for multicycle_control. Each stimulus cycle pushes a
// hand-written expected output word into a scoreboard queue; an independent
// monitor pops and compares one entry per cycle on the falling edge.
// Output word layout (18 bits, MSB first):
//   mem_req mem_we mux_iord ir_write pc_write mux_pc_src[1:0] write_reg
//   mux_write_rt_rd mux_alu_a mux_alu_b[1:0] alu_op[3:0]
//   mux_reg_src_alu_mem illegal
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic clk;
  logic rst;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [17:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          passes;

  logic [17:0] e_rst, e_fwait, e_fdone, e_dec, e_exr, e_wbr, e_exi_add;
  logic [17:0] e_exi_and, e_wbi, e_addr, e_mrd, e_wbm, e_mwr, e_mwr_rst;
  logic [17:0] e_beq_t, e_bne_nt, e_bne_t, e_jmp, e_trap;

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(
    input logic mr, input logic we, input logic iord, input logic irw,
    input logic pcw, input logic [1:0] pcsrc, input logic wr,
    input logic rtrd, input logic alua, input logic [1:0] alub,
    input logic [3:0] op, input logic regsrc, input logic ill);
    return {mr, we, iord, irw, pcw, pcsrc, wr, rtrd, alua, alub, op, regsrc, ill};
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its
  // expected outputs for the monitor
  task automatic applyStimulus(input logic r, input logic [5:0] op,
                               input logic z, input logic rdy,
                               input logic [17:0] expv, input string nm);
    @(posedge clk);
    #1;
    rst           = r;
    bus.opcode    = op;
    bus.alu_zero  = z;
    bus.mem_ready = rdy;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  task automatic checkOutput(input logic [17:0] expv, input string nm);
    logic [17:0] act;
    act = {bus.mem_req, bus.mem_we, bus.mux_iord, bus.ir_write, bus.pc_write,
           bus.mux_pc_src, bus.write_reg, bus.mux_write_rt_rd, bus.mux_alu_a,
           bus.mux_alu_b, bus.alu_op, bus.mux_reg_src_alu_mem, bus.illegal};
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %05h expected %05h at %0t", nm, act, expv, $time);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(e, n);
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    rst           = 1'b1;
    bus.opcode    = 6'b000000;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;

    e_rst     = mk(0,0,0,0,0,2'b00,0,0,0,2'b01,4'h0,0,0);
    e_fwait   = mk(1,0,0,0,0,2'b00,0,0,0,2'b01,4'h0,0,0);
    e_fdone   = mk(1,0,0,1,1,2'b00,0,0,0,2'b01,4'h0,0,0);
    e_dec     = mk(0,0,0,0,0,2'b00,0,0,0,2'b11,4'h0,0,0);
    e_exr     = mk(0,0,0,0,0,2'b00,0,0,1,2'b00,4'h2,0,0);
    e_wbr     = mk(0,0,0,0,0,2'b00,1,1,0,2'b00,4'h0,1,0);
    e_exi_add = mk(0,0,0,0,0,2'b00,0,0,1,2'b10,4'h0,0,0);
    e_exi_and = mk(0,0,0,0,0,2'b00,0,0,1,2'b10,4'h3,0,0);
    e_wbi     = mk(0,0,0,0,0,2'b00,1,0,0,2'b00,4'h0,1,0);
    e_addr    = mk(0,0,0,0,0,2'b00,0,0,1,2'b10,4'h0,0,0);
    e_mrd     = mk(1,0,1,0,0,2'b00,0,0,0,2'b00,4'h0,0,0);
    e_wbm     = mk(0,0,0,0,0,2'b00,1,0,0,2'b00,4'h0,0,0);
    e_mwr     = mk(1,1,1,0,0,2'b00,0,0,0,2'b00,4'h0,0,0);
    e_mwr_rst = mk(0,0,1,0,0,2'b00,0,0,0,2'b00,4'h0,0,0);
    e_beq_t   = mk(0,0,0,0,1,2'b01,0,0,1,2'b00,4'h1,0,0);
    e_bne_nt  = mk(0,0,0,0,0,2'b01,0,0,1,2'b00,4'h4,0,0);
    e_bne_t   = mk(0,0,0,0,1,2'b01,0,0,1,2'b00,4'h4,0,0);
    e_jmp     = mk(0,0,0,0,1,2'b10,0,0,0,2'b00,4'h0,0,0);
    e_trap    = mk(0,0,0,0,0,2'b00,0,0,0,2'b00,4'h0,0,1);

    // Reset held two cycles: FETCH muxes visible, enables suppressed
    applyStimulus(1, 6'b000000, 0, 1, e_rst, "reset_c1");
    applyStimulus(1, 6'b000000, 0, 1, e_rst, "reset_c2");

    // add, zero wait: write_reg in cycle 4, fetch again in cycle 5
    applyStimulus(0, 6'b000000, 0, 1, e_fdone, "add_fetch");
    applyStimulus(0, 6'b000000, 0, 1, e_dec,   "add_decode");
    applyStimulus(0, 6'b000000, 0, 1, e_exr,   "add_exec");
    applyStimulus(0, 6'b000000, 0, 1, e_wbr,   "add_wb");

    // andi
    applyStimulus(0, 6'b001100, 0, 1, e_fdone,   "andi_fetch");
    applyStimulus(0, 6'b001100, 0, 1, e_dec,     "andi_decode");
    applyStimulus(0, 6'b001100, 0, 1, e_exi_and, "andi_exec");
    applyStimulus(0, 6'b001100, 0, 1, e_wbi,     "andi_wb");

    // addiu
    applyStimulus(0, 6'b001001, 0, 1, e_fdone,   "addiu_fetch");
    applyStimulus(0, 6'b001001, 0, 1, e_dec,     "addiu_decode");
    applyStimulus(0, 6'b001001, 0, 1, e_exi_add, "addiu_exec");
    applyStimulus(0, 6'b001001, 0, 1, e_wbi,     "addiu_wb");

    // lw with three wait cycles in MEM_RD: write-back lands in cycle 8
    applyStimulus(0, 6'b100011, 0, 1, e_fdone, "lw_fetch");
    applyStimulus(0, 6'b100011, 0, 1, e_dec,   "lw_decode");
    applyStimulus(0, 6'b100011, 0, 1, e_addr,  "lw_addr");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 6'b100011, 0, 0, e_mrd, "lw_mem_wait");
    applyStimulus(0, 6'b100011, 0, 1, e_mrd,   "lw_mem_done");
    applyStimulus(0, 6'b100011, 0, 1, e_wbm,   "lw_wb");

    // sw with one fetch wait state
    applyStimulus(0, 6'b101011, 0, 0, e_fwait, "sw_fetch_wait");
    applyStimulus(0, 6'b101011, 0, 1, e_fdone, "sw_fetch");
    applyStimulus(0, 6'b101011, 0, 1, e_dec,   "sw_decode");
    applyStimulus(0, 6'b101011, 0, 1, e_addr,  "sw_addr");
    applyStimulus(0, 6'b101011, 0, 1, e_mwr,   "sw_mem");

    // beq taken, bne not taken, bne taken
    applyStimulus(0, 6'b000100, 1, 1, e_fdone,  "beq_fetch");
    applyStimulus(0, 6'b000100, 1, 1, e_dec,    "beq_decode");
    applyStimulus(0, 6'b000100, 1, 1, e_beq_t,  "beq_taken");
    applyStimulus(0, 6'b000101, 1, 1, e_fdone,  "bne_fetch");
    applyStimulus(0, 6'b000101, 1, 1, e_dec,    "bne_decode");
    applyStimulus(0, 6'b000101, 1, 1, e_bne_nt, "bne_not_taken");
    applyStimulus(0, 6'b000101, 0, 1, e_fdone,  "bne2_fetch");
    applyStimulus(0, 6'b000101, 0, 1, e_dec,    "bne2_decode");
    applyStimulus(0, 6'b000101, 0, 1, e_bne_t,  "bne_taken");

    // jump
    applyStimulus(0, 6'b000010, 0, 1, e_fdone, "j_fetch");
    applyStimulus(0, 6'b000010, 0, 1, e_dec,   "j_decode");
    applyStimulus(0, 6'b000010, 0, 1, e_jmp,   "j_jump");

    // sw interrupted by reset while memory is still busy
    applyStimulus(0, 6'b101011, 0, 1, e_fdone,   "swr_fetch");
    applyStimulus(0, 6'b101011, 0, 1, e_dec,     "swr_decode");
    applyStimulus(0, 6'b101011, 0, 1, e_addr,    "swr_addr");
    applyStimulus(0, 6'b101011, 0, 0, e_mwr,     "swr_mem_wait");
    applyStimulus(1, 6'b101011, 0, 0, e_mwr_rst, "swr_rst_in_mem");
    applyStimulus(0, 6'b101011, 0, 0, e_fwait,   "swr_refetch");
    applyStimulus(0, 6'b101011, 0, 1, e_fdone,   "swr_refetch_done");

    // illegal opcode traps and stays quiet even with mem_ready high
    applyStimulus(0, 6'b111111, 0, 1, e_dec, "ill_decode");
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 6'b111111, 0, 1, e_trap, "trap_hold");
    applyStimulus(1, 6'b111111, 0, 1, e_trap,  "trap_rst");
    applyStimulus(0, 6'b000000, 0, 0, e_fwait, "trap_cleared_fetch");
    applyStimulus(0, 6'b000000, 0, 1, e_fdone, "post_trap_fetch");
    applyStimulus(0, 6'b000000, 0, 1, e_dec,   "post_trap_decode");

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
